gift_effect_ctrl: RTL
=====================

Name: gift_effect_ctrl

Overview:
- Sits directly downstream of the gift generator / falling-gift logic.
- Consumes one "gift caught" event carrying a 3-bit kind and turns it into effect state for the game:
  - persistent paddle-size and ball-speed levels;
  - timed hide and shoot effects;
  - one-cycle drop and multiball requests.
- All effects are cleared when the ball is lost.
- Outputs feed the paddle, ball and brick controllers.

Parameters:
- DUR_TICKS, 600, frame ticks a timed effect (HID, SOT) lasts (10 s at 60 Hz); max 1023.
- LVL_DEFAULT, 1, reset/lost value of paddle-size and speed levels (range 0..3).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tick  in  1  one-cycle frame strobe; timers decrement on it
- lost  in  1  ball lost; clears all effects
- catch_valid  in  1  one-cycle pulse: gift caught this cycle
- catch_kind  in  3  kind of caught gift, valid with catch_valid
- pd_level  out  2  paddle-size level, 0 = narrowest, 3 = widest
- spd_level  out  2  ball-speed level, 0 = slowest, 3 = fastest
- hide_on  out  1  hide effect active
- shoot_on  out  1  paddle shooting enabled
- drop_req  out  1  one-cycle pulse: brick field drops one row
- multi_req  out  1  one-cycle pulse: spawn extra balls
- caught_cnt  out  8  gifts caught since reset, saturating

Behaviour:
- Clocking: single clock; every register updates on the rising edge of clock.
- Reset values: pd_level = spd_level = LVL_DEFAULT; hide_on = shoot_on = drop_req = multi_req = 0; caught_cnt = 0; both timers = 0.
- Latency: outputs reflect a catch on the first rising edge after catch_valid is sampled high (1-cycle latency).
- Kind decode (package constants):
  - INC=0: pd_level+1, saturating at 3.
  - DEC=1: pd_level-1, saturating at 0.
  - SPU=2: spd_level+1, saturating at 3.
  - SPD=3: spd_level-1, saturating at 0.
  - HID=4: hide timer loaded with DUR_TICKS; hide_on=1.
  - SOT=5: shoot timer loaded with DUR_TICKS; shoot_on=1.
  - DRP=6: drop_req=1 for exactly one cycle.
  - MUL=7: multi_req=1 for exactly one cycle.
- Timers:
  - Two independent 10-bit down-counters, hide and shoot. Each has two states: IDLE (count 0, flag 0) and RUN (count > 0, flag 1).
  - In RUN, each tick decrements the count. The flag deasserts on the same edge that the count reaches 0.
  - A catch of the same kind while in RUN reloads the count to DUR_TICKS; there is no accumulation.
  - If tick and a reload occur in the same cycle, the reload wins and no decrement is applied.
- caught_cnt: increments on every accepted catch (any kind), saturating at 255. It is not cleared by lost.
- lost:
  - On the next edge: pd_level and spd_level return to LVL_DEFAULT; both timers go to 0; hide_on and shoot_on go to 0.
  - A catch_valid in the same cycle as lost is discarded entirely: no effect, no pulse, no count increment.
- Pulses: drop_req and multi_req are registered. They are high only in the cycle after the catch and never stretch, even if back-to-back catches arrive.
- Back-to-back catches: one per cycle is accepted; each is processed independently.
- catch_kind: ignored when catch_valid = 0.
- reset: overrides lost, tick and catch at any time, including mid-timer.
- Arithmetic: saturation is evaluated on the current register value; wrap-around is forbidden (DEC at 0 stays 0, INC at 3 stays 3).

Decomposition:
- Shared package gift_pkg:
  - 3-bit kind constants INC, DEC, SPU, SPD, HID, SOT, DRP, MUL (the same encoding the generator uses);
  - level width (2) and LVL_DEFAULT;
  - timer width (10).
- One sub-module effect_timer:
  - inputs: clock, reset, clr (lost), load, tick;
  - outputs: active flag;
  - parameterised by DUR_TICKS;
  - instantiated twice (hide, shoot).
- Level saturation logic and pulse generation stay in the top.

Test Plan:
- Reset, then idle 10 cycles → pd_level=1, spd_level=1, hide_on=0, shoot_on=0, drop_req=0, multi_req=0, caught_cnt=0.
- Four INC catches on consecutive cycles → pd_level goes 2, 3, 3, 3 and caught_cnt=4. Then five DEC catches → pd_level ends at 0 with no wrap.
- HID catch with DUR_TICKS=4, then one tick every 3 cycles → hide_on=1 for exactly 4 ticks and drops on the edge of the 4th. A HID re-catch after 2 ticks, coincident with a tick → 4 further ticks required.
- DRP then MUL catches on consecutive cycles → drop_req high exactly 1 cycle, multi_req high exactly 1 cycle the following cycle, never overlapping.
- Set spd_level=3, shoot_on=1, then assert lost together with catch_valid/kind=INC → next cycle: pd_level=1, spd_level=1, shoot_on=0, caught_cnt unchanged.
- 300 catches → caught_cnt holds at 255. Assert reset mid-SOT timer → all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/gift_pkg.sv
// Shared definitions for the gift pipeline: kind encoding, level and timer widths.
package gift_pkg;

    typedef enum logic [2:0] {
        INC = 3'd0,
        DEC = 3'd1,
        SPU = 3'd2,
        SPD = 3'd3,
        HID = 3'd4,
        SOT = 3'd5,
        DRP = 3'd6,
        MUL = 3'd7
    } gift_kind_e;

    localparam int                LVL_W       = 2;
    localparam logic [LVL_W-1:0]  LVL_DEFAULT = 2'd1;
    localparam logic [LVL_W-1:0]  LVL_MAX     = 2'd3;
    localparam int                TMR_W       = 10;
    localparam int                CNT_W       = 8;

    typedef enum logic {
        TMR_IDLE,
        TMR_RUN
    } tmr_state_e;

    // Saturating one-step move of a level; never wraps at 0 or LVL_MAX.
    function automatic logic [LVL_W-1:0] lvl_step(input logic [LVL_W-1:0] lvl,
                                                  input logic             up);
        if (up)
            return (lvl == LVL_MAX) ? lvl : lvl + 1'b1;
        else
            return (lvl == '0) ? lvl : lvl - 1'b1;
    endfunction

endpackage

// File: rtl/effect_timer.sv
// Reloadable frame-tick down-counter driving one timed effect flag.
//   state    | meaning
//   TMR_IDLE | count 0, effect off
//   TMR_RUN  | count > 0, effect on; decrements on tick
module effect_timer
    import gift_pkg::*;
#(
    parameter int DUR_TICKS = 600
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic load,
    input  logic tick,
    output logic active
);

    tmr_state_e       state_q, state_d;
    logic [TMR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= TMR_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clr) begin
            state_d = TMR_IDLE;
            cnt_d   = '0;
        end else if (load && (DUR_TICKS != 0)) begin
            // Reload wins over a coincident tick; no accumulation.
            state_d = TMR_RUN;
            cnt_d   = TMR_W'(DUR_TICKS);
        end else if ((state_q == TMR_RUN) && tick) begin
            if (cnt_q <= TMR_W'(1)) begin
                state_d = TMR_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d   = cnt_q - 1'b1;
            end
        end
    end

    assign active = (state_q == TMR_RUN);

endmodule

// File: rtl/gift_effect_ctrl.sv
// Turns caught-gift events into paddle/ball/brick effect state; lost clears effects.
module gift_effect_ctrl #(
    parameter int                          DUR_TICKS   = 600,
    parameter logic [gift_pkg::LVL_W-1:0]  LVL_DEFAULT = gift_pkg::LVL_DEFAULT
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        tick,
    input  logic                        lost,
    input  logic                        catch_valid,
    input  logic [2:0]                  catch_kind,
    output logic [gift_pkg::LVL_W-1:0]  pd_level,
    output logic [gift_pkg::LVL_W-1:0]  spd_level,
    output logic                        hide_on,
    output logic                        shoot_on,
    output logic                        drop_req,
    output logic                        multi_req,
    output logic [gift_pkg::CNT_W-1:0]  caught_cnt
);
    import gift_pkg::*;

    logic [LVL_W-1:0] pd_q, pd_d;
    logic [LVL_W-1:0] spd_q, spd_d;
    logic             drop_q, drop_d;
    logic             multi_q, multi_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    gift_kind_e       kind;

    // A catch coincident with lost is dropped entirely.
    assign accept = catch_valid && !lost;
    assign kind   = gift_kind_e'(catch_kind);

    always_ff @(posedge clock) begin
        if (reset) begin
            pd_q    <= LVL_DEFAULT;
            spd_q   <= LVL_DEFAULT;
            drop_q  <= 1'b0;
            multi_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pd_q    <= pd_d;
            spd_q   <= spd_d;
            drop_q  <= drop_d;
            multi_q <= multi_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        pd_d    = pd_q;
        spd_d   = spd_q;
        drop_d  = 1'b0;
        multi_d = 1'b0;
        cnt_d   = cnt_q;
        if (lost) begin
            pd_d  = LVL_DEFAULT;
            spd_d = LVL_DEFAULT;
        end else if (catch_valid) begin
            unique case (kind)
                INC:     pd_d    = lvl_step(pd_q, 1'b1);
                DEC:     pd_d    = lvl_step(pd_q, 1'b0);
                SPU:     spd_d   = lvl_step(spd_q, 1'b1);
                SPD:     spd_d   = lvl_step(spd_q, 1'b0);
                DRP:     drop_d  = 1'b1;
                MUL:     multi_d = 1'b1;
                default: ;
            endcase
            if (cnt_q != {CNT_W{1'b1}})
                cnt_d = cnt_q + 1'b1;
        end
    end

    effect_timer #(.DUR_TICKS(DUR_TICKS)) u_hide_tmr (
        .clock  (clock),
        .reset  (reset),
        .clr    (lost),
        .load   (accept && (kind == HID)),
        .tick   (tick),
        .active (hide_on)
    );

    effect_timer #(.DUR_TICKS(DUR_TICKS)) u_shoot_tmr (
        .clock  (clock),
        .reset  (reset),
        .clr    (lost),
        .load   (accept && (kind == SOT)),
        .tick   (tick),
        .active (shoot_on)
    );

    assign pd_level   = pd_q;
    assign spd_level  = spd_q;
    assign drop_req   = drop_q;
    assign multi_req  = multi_q;
    assign caught_cnt = cnt_q;

endmodule
